serial_tx: RTL and testbench
============================

// Module: serial_tx
// PURPOSE
//  Bit-serial transmitter: accepts a WIDTH-bit word on a valid/ready handshake,
//  sends it on one line as start bit (0), WIDTH data bits LSB first, stop bit (1).
//  Each bit is held for DIV clocks. It is the sending end of the serial link whose
//  receive side is a capture chain of D flip-flops. It sits between a CPU I/O
//  register and the off-chip line.
// PARAMETERS
//  WIDTH  8  data bits per frame (>=1)
//  DIV    4  clocks per bit (>=1); DIV=1 sends one bit per clock
// PORTS
//  clk    in   1      clock; all state changes on posedge clk
//  clr    in   1      reset, synchronous, active-high
//  din    in   WIDTH  word to send; sampled only on the accept edge
//  valid  in   1      din holds a word to send
//  ready  out  1      block can accept a word (IDLE and clr low)
//  tx     out  1      serial line; idles high
//  busy   out  1      frame in progress (START/DATA/STOP)
//  done   out  1      one-clock pulse when the stop bit completes
// BEHAVIOUR
//  - Reset: while clr is high at a posedge, the next state is IDLE, tx=1, busy=0,
//    done=0, and all counters are 0. ready is 0 while clr is high and 1 after.
//    clr overrides every other input.
//  - clr mid-frame: the frame is aborted. tx=1 from the next edge. No done pulse.
//  - tx, busy and done are registered. ready = (state==IDLE) & ~clr.
//  - Accept: valid&ready sampled at edge E0. din is latched into the shift register.
//    After E0: state=START, tx=0, busy=1. Later changes on din have no effect.
//  - FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//    START: tx=0 for DIV clocks, then go to DATA.
//    DATA: tx=shreg[0]. Every DIV clocks, shift right and increment the bit counter.
//    After WIDTH bits, go to STOP.
//    STOP: tx=1 for DIV clocks, then go to IDLE.
//  - Divider counter: counts 0..DIV-1 and wraps. Bit boundary is div_cnt==DIV-1.
//    Width is max(1,$clog2(DIV)). Bit counter width is max(1,$clog2(WIDTH+1)).
//  - Timing: frame is (WIDTH+2)*DIV clocks. Bit k (0=start) drives tx after edge E0+k*DIV.
//    At E0+(WIDTH+2)*DIV: state=IDLE, tx=1, busy=0, done=1 for exactly one clock.
//  - Back-to-back: valid held high is next accepted at E0+(WIDTH+2)*DIV+1.
//    The minimum frame period is therefore (WIDTH+2)*DIV+1 clocks, with one extra idle-high clock.
//  - valid while busy is ignored (ready=0). No word is queued and nothing is lost
//    silently: the source holds valid until ready.
//  - valid deasserted in IDLE: the line stays high, the FSM stays in IDLE, outputs are steady.
// TESTING
//  1 Reset: clr=1 for 3 clocks with valid=1 -> tx=1, busy=0, done=0, ready=0.
//    Release clr -> ready=1. No frame starts until valid is sampled with clr=0.
//  2 Single frame (WIDTH=8, DIV=4): din=8'hA5 accepted at E0 -> tx = 0,1,0,1,0,0,1,0,1,1,
//    each held 4 clocks. done=1 only in the clock after E40. busy=1 from E0 to E40.
//  3 Back-to-back: valid held with 8'h00 then 8'hFF -> second start bit begins after E41.
//    tx=1 for exactly one clock between frames. Two done pulses, 41 clocks apart.
//  4 din changed to 8'h3C one clock after accepting 8'hC3 -> line still carries 8'hC3.
//    valid pulses during busy are ignored.
//  5 clr at E20 mid-frame -> tx=1 and busy=0 after E20, no done pulse.
//    A new word 8'h5A is accepted normally after clr drops.
//  6 DIV=1, WIDTH=1: din=1 -> tx = 0,1,1, one clock each. done after E3.
//    Next accept is possible at E4.

Source files
------------

// File: rtl/serial_tx.sv
// Bit-serial transmitter: start bit, WIDTH data bits LSB first, stop bit,
// each bit held for DIV clocks, with a valid/ready word handshake.
module serial_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = ($clog2(WIDTH + 1) > 1) ? $clog2(WIDTH + 1) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           r_state;
  logic [DW-1:0]    r_divCnt;
  logic [BW-1:0]    r_bitCnt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shNext;
  logic             w_bitEnd;

  assign w_shNext = r_shreg >> 1;
  assign w_bitEnd = (r_divCnt == DIV_LAST);
  assign o_ready  = (r_state == IDLE) && !i_clr;

  // tx always carries the bit that the state being entered will present.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state  <= IDLE;
      r_divCnt <= '0;
      r_bitCnt <= '0;
      r_shreg  <= '0;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_shreg  <= i_din;
            r_divCnt <= '0;
            r_bitCnt <= '0;
            r_state  <= START;
            o_tx     <= 1'b0;
            o_busy   <= 1'b1;
          end
        end
        START: begin
          if (w_bitEnd) begin
            r_divCnt <= '0;
            r_state  <= DATA;
            o_tx     <= r_shreg[0];
          end else begin
            r_divCnt <= r_divCnt + DW'(1);
          end
        end
        DATA: begin
          if (w_bitEnd) begin
            r_divCnt <= '0;
            r_shreg  <= w_shNext;
            if (r_bitCnt == BIT_LAST) begin
              r_bitCnt <= '0;
              r_state  <= STOP;
              o_tx     <= 1'b1;
            end else begin
              r_bitCnt <= r_bitCnt + BW'(1);
              o_tx     <= w_shNext[0];
            end
          end else begin
            r_divCnt <= r_divCnt + DW'(1);
          end
        end
        STOP: begin
          if (w_bitEnd) begin
            r_divCnt <= '0;
            r_state  <= IDLE;
            o_tx     <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
          end else begin
            r_divCnt <= r_divCnt + DW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          o_tx    <= 1'b1;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: two instances (8-bit/DIV=4 and 1-bit/DIV=1)
// compared every cycle against a frame-timing model, plus directed literal checks.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       clr   [2];
  logic       valid [2];
  logic [7:0] din   [2];
  logic       ready [2];
  logic       tx    [2];
  logic       busy  [2];
  logic       done  [2];

  int W_OF [2] = '{8, 1};
  int D_OF [2] = '{4, 1};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic checkEn = 1'b0;

  logic       mActive  [2] = '{1'b0, 1'b0};
  logic       mDone    [2] = '{1'b0, 1'b0};
  int         mElapsed [2] = '{0, 0};
  logic [7:0] mWord    [2];
  int doneQ0 [$];

  always #5 clk = ~clk;

  serial_tx #(.WIDTH(8), .DIV(4)) dut0 (
    .i_clk(clk), .i_clr(clr[0]), .i_din(din[0]), .i_valid(valid[0]),
    .o_ready(ready[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0])
  );

  serial_tx #(.WIDTH(1), .DIV(1)) dut1 (
    .i_clk(clk), .i_clr(clr[1]), .i_din(din[1][0:0]), .i_valid(valid[1]),
    .o_ready(ready[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1])
  );

  // Frame model: a frame is just "edges elapsed since accept"; the line value
  // follows from which bit slot that count falls into.
  always @(posedge clk) begin
    cyc++;
    for (int u = 0; u < 2; u++) begin
      if (clr[u]) begin
        mActive[u] = 1'b0;
        mDone[u]   = 1'b0;
      end else if (mActive[u]) begin
        mElapsed[u]++;
        if (mElapsed[u] == (W_OF[u] + 2) * D_OF[u]) begin
          mActive[u] = 1'b0;
          mDone[u]   = 1'b1;
        end else begin
          mDone[u] = 1'b0;
        end
      end else begin
        mDone[u] = 1'b0;
        if (valid[u]) begin
          mActive[u]  = 1'b1;
          mElapsed[u] = 0;
          mWord[u]    = din[u];
        end
      end
    end
  end

  function automatic logic txExp(int u);
    int k;
    if (!mActive[u]) return 1'b1;
    k = mElapsed[u] / D_OF[u];
    if (k == 0) return 1'b0;
    if (k <= W_OF[u]) return mWord[u][k-1];
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Continuous comparison of both instances against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int u = 0; u < 2; u++) begin
        checkOutput($sformatf("u%0d tx", u),    tx[u],    txExp(u));
        checkOutput($sformatf("u%0d busy", u),  busy[u],  mActive[u]);
        checkOutput($sformatf("u%0d done", u),  done[u],  mDone[u]);
        checkOutput($sformatf("u%0d ready", u), ready[u], !mActive[u] && !clr[u]);
      end
      if (done[0] === 1'b1) doneQ0.push_back(cyc);
    end
  end

  task automatic applyStimulus(input int u, input logic [7:0] word);
    @(posedge clk); #2;
    din[u]   = word;
    valid[u] = 1'b1;
    @(posedge clk); #2;
    valid[u] = 1'b0;
  endtask

  initial begin
    logic [9:0] a5Seq;
    logic [7:0] c3;
    a5Seq = 10'b1101001010;
    c3    = 8'hC3;

    for (int u = 0; u < 2; u++) begin
      clr[u]   = 1'b1;
      valid[u] = 1'b1;
      din[u]   = 8'h77;
    end

    // Reset held with valid asserted
    @(posedge clk); #2;
    checkEn = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset tx", tx[0], 1'b1);
    checkOutput("reset busy", busy[0], 1'b0);
    checkOutput("reset done", done[0], 1'b0);
    checkOutput("reset ready", ready[0], 1'b0);
    for (int u = 0; u < 2; u++) begin
      valid[u] = 1'b0;
      clr[u]   = 1'b0;
    end
    #1;
    checkOutput("ready after clr", ready[0], 1'b1);
    @(posedge clk); #2;
    checkOutput("idle busy", busy[0], 1'b0);

    // Single frame 8'hA5
    applyStimulus(0, 8'hA5);
    for (int m = 0; m < 40; m++) begin
      checkOutput($sformatf("A5 slot %0d", m), tx[0], a5Seq[m/4]);
      checkOutput("A5 busy", busy[0], 1'b1);
      @(posedge clk); #2;
    end
    checkOutput("A5 done pulse", done[0], 1'b1);
    checkOutput("A5 busy end", busy[0], 1'b0);
    @(posedge clk); #2;
    checkOutput("A5 done width", done[0], 1'b0);

    // Back-to-back with valid held
    doneQ0.delete();
    din[0]   = 8'h00;
    valid[0] = 1'b1;
    @(posedge clk); #2;
    din[0] = 8'hFF;
    repeat (40) @(posedge clk);
    #2;
    checkOutput("b2b gap tx", tx[0], 1'b1);
    checkOutput("b2b gap busy", busy[0], 1'b0);
    @(posedge clk); #2;
    valid[0] = 1'b0;
    checkOutput("b2b second start", tx[0], 1'b0);
    repeat (45) @(posedge clk);
    #2;
    checks++;
    if (doneQ0.size() != 2 || (doneQ0[1] - doneQ0[0]) != 41) begin
      errors++;
      $display("[TB] FAIL b2b done spacing: got %0d pulses, expected 2 pulses 41 apart",
               doneQ0.size());
    end

    // din changes after accept; valid pulses while busy
    @(posedge clk); #2;
    din[0]   = 8'hC3;
    valid[0] = 1'b1;
    @(posedge clk); #2;
    valid[0] = 1'b0;
    din[0]   = 8'h3C;
    for (int i = 1; i < 40; i++) begin
      @(posedge clk); #2;
      valid[0] = (i <= 38) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i % 4 == 2 && i >= 4 && i < 36)
        checkOutput($sformatf("C3 bit %0d", i/4 - 1), tx[0], c3[i/4 - 1]);
    end
    repeat (5) @(posedge clk);

    // clr mid-frame
    doneQ0.delete();
    applyStimulus(0, 8'h96);
    repeat (18) @(posedge clk);
    #2;
    clr[0] = 1'b1;
    @(posedge clk); #2;
    clr[0] = 1'b0;
    checkOutput("abort tx", tx[0], 1'b1);
    checkOutput("abort busy", busy[0], 1'b0);
    repeat (30) @(posedge clk);
    #2;
    checks++;
    if (doneQ0.size() != 0) begin
      errors++;
      $display("[TB] FAIL abort done: got %0d pulses, expected 0", doneQ0.size());
    end
    applyStimulus(0, 8'h5A);
    checkOutput("post-abort start", tx[0], 1'b0);
    repeat (45) @(posedge clk);

    // DIV=1, WIDTH=1 instance
    @(posedge clk); #2;
    din[1]   = 8'h01;
    valid[1] = 1'b1;
    @(posedge clk); #2;
    checkOutput("w1 start", tx[1], 1'b0);
    @(posedge clk); #2;
    checkOutput("w1 data", tx[1], 1'b1);
    @(posedge clk); #2;
    checkOutput("w1 stop", tx[1], 1'b1);
    checkOutput("w1 stop busy", busy[1], 1'b1);
    @(posedge clk); #2;
    checkOutput("w1 done", done[1], 1'b1);
    checkOutput("w1 idle busy", busy[1], 1'b0);
    @(posedge clk); #2;
    checkOutput("w1 re-accept tx", tx[1], 1'b0);
    checkOutput("w1 re-accept busy", busy[1], 1'b1);
    valid[1] = 1'b0;
    repeat (5) @(posedge clk);

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #2;
      for (int u = 0; u < 2; u++) begin
        valid[u] = ($urandom_range(0, 2) == 0);
        din[u]   = 8'($urandom);
        clr[u]   = ($urandom_range(0, 149) == 0);
      end
    end
    @(posedge clk); #2;
    for (int u = 0; u < 2; u++) begin
      valid[u] = 1'b0;
      clr[u]   = 1'b0;
    end
    repeat (50) @(posedge clk);
    #2;
    checkEn = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
